fir_transposed_seg: RTL

Parametrised transposed-form FIR tap segment: the successor to the fixed 3-tap multiply/add/shift output stage in the Transposed FIR datapath. It generalises tap count and widths, adds a double-buffered coefficient bank with sample-aligned swap, and adds a registered round/shift/saturate output stage with a sticky overflow flag. Segments cascade through `iCascadeIn`/`oCascadeOut` to build longer filters; the last segment drives the filter output.

---
 rtl/fir_pkg.sv | 55 +++++
 rtl/fir_round_sat.sv | 66 ++++++
 rtl/fir_transposed_seg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default datapath widths and the round/shift/saturate
// helper used by both the transposed-form segment and the direct-form FIR.
//
// Contents
//   FIR_* localparams : default parameter values for FIR blocks
//   SR_W              : working width of sat_round (wide enough for any ACC_W < 64)
//   sat_round_t       : result of sat_round (clamped value + overflow flag)
//   sat_round()       : (acc + 2^(shift-1)) >>> shift, clamped to a signed outW range
package fir_pkg;

  localparam int FIR_TAPS   = 3;
  localparam int FIR_DIN_W  = 3;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_ACC_W  = 24;
  localparam int FIR_OUT_W  = 16;
  localparam int FIR_SHIFT  = 0;

  localparam int SR_W = 64;

  typedef struct packed {
    logic signed [SR_W-1:0] value;
    logic                   sat;
  } sat_round_t;

  // The rounding add is done at 64 bits so it can never wrap for any
  // accumulator narrower than that; the clamp then compares against the
  // signed limits of the requested output width.
  function automatic sat_round_t sat_round(input logic signed [SR_W-1:0] acc,
                                           input int shift,
                                           input int outW);
    logic signed [SR_W-1:0] rounded;
    logic signed [SR_W-1:0] shifted;
    logic signed [SR_W-1:0] maxVal;
    logic signed [SR_W-1:0] minVal;
    sat_round_t res;
    rounded = acc;
    if (shift > 0) begin
      rounded = acc + (SR_W'(1) <<< (shift - 1));
    end
    shifted   = rounded >>> shift;
    maxVal    = (SR_W'(1) <<< (outW - 1)) - SR_W'(1);
    minVal    = -(SR_W'(1) <<< (outW - 1));
    res.value = shifted;
    res.sat   = 1'b0;
    if (shifted > maxVal) begin
      res.value = maxVal;
      res.sat   = 1'b1;
    end else if (shifted < minVal) begin
      res.value = minVal;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Registered FIR output stage: rounds, shifts and saturates the full-precision
// accumulator into the output width and keeps a sticky saturation flag.
//
// Ports
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   valid_i       : acc_i holds a new result this cycle
//   acc_i         : full-precision signed accumulator
//   clrSat_i      : clear the sticky saturation flag
//   data_o        : rounded/shifted/clamped result, held between updates
//   valid_o       : one-cycle pulse, data_o was just updated
//   sat_o         : sticky, a clamp occurred since the last clear
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = FIR_ACC_W,
  parameter int OUT_W = FIR_OUT_W,
  parameter int SHIFT = FIR_SHIFT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic                    clrSat_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    valid_o,
  output logic                    sat_o
);

  sat_round_t              satRes;
  logic signed [OUT_W-1:0] data_q;
  logic                    valid_q;
  logic                    sat_q;
  logic                    unusedRoundBits;

  always_comb begin
    satRes = sat_round(SR_W'(acc_i), SHIFT, OUT_W);
  end

  // After the clamp the upper bits are only sign copies of the kept slice.
  assign unusedRoundBits = ^satRes.value[SR_W-1:OUT_W];

  // A clamp on this cycle's result takes priority over a clear request so a
  // fresh overflow is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= satRes.value[OUT_W-1:0];
      end
      if (valid_i && satRes.sat) begin
        sat_q <= 1'b1;
      end else if (clrSat_i) begin
        sat_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/fir_transposed_seg.sv
// Transposed-form FIR tap segment with a double-buffered coefficient bank and
// a registered round/shift/saturate output stage. Segments chain through
// iCascadeIn/oCascadeOut; the last one in the chain drives the filter output.
//
// Ports
//   iClk_12M, iRsn  : clock, asynchronous active-low reset
//   iEnSample_300k  : one-cycle strobe per input sample, iFirIn valid with it
//   iFirIn          : signed input sample
//   iCascadeIn      : partial sum from the upstream segment (0 if first)
//   iCoeffWe/Addr/Data : write into the shadow coefficient bank
//   iCoeffSwap      : request a shadow -> active copy on a later strobe
//   iClrSat         : clear the sticky saturation flag
//   oCascadeOut     : last chain register, full precision, to downstream
//   oFirOut, oValid : rounded/saturated output and its one-cycle valid pulse
//   oSwapPending    : swap requested but not yet applied
//   oSat            : sticky saturation flag
module fir_transposed_seg
  import fir_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS,
  parameter int DIN_W  = FIR_DIN_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int ACC_W  = FIR_ACC_W,
  parameter int OUT_W  = FIR_OUT_W,
  parameter int SHIFT  = FIR_SHIFT
) (
  input  logic                     iClk_12M,
  input  logic                     iRsn,
  input  logic                     iEnSample_300k,
  input  logic signed [DIN_W-1:0]  iFirIn,
  input  logic signed [ACC_W-1:0]  iCascadeIn,
  input  logic                     iCoeffWe,
  input  logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] iCoeffAddr,
  input  logic signed [COEF_W-1:0] iCoeffData,
  input  logic                     iCoeffSwap,
  input  logic                     iClrSat,
  output logic signed [ACC_W-1:0]  oCascadeOut,
  output logic signed [OUT_W-1:0]  oFirOut,
  output logic                     oValid,
  output logic                     oSwapPending,
  output logic                     oSat
);

  localparam int PROD_W = DIN_W + COEF_W;

  logic signed [COEF_W-1:0] coefActive_q [TAPS];
  logic signed [COEF_W-1:0] coefActive_d [TAPS];
  logic signed [COEF_W-1:0] coefShadow_q [TAPS];
  logic signed [COEF_W-1:0] coefShadow_d [TAPS];
  logic signed [ACC_W-1:0]  rShift_q     [TAPS];
  logic signed [ACC_W-1:0]  rShift_d     [TAPS];
  logic signed [PROD_W-1:0] tapProd      [TAPS];
  logic                     swapPending_q;
  logic                     swapPending_d;
  logic                     strobeDly_q;
  logic                     applySwap;

  // A swap is only applied on a strobe when it was already pending from an
  // earlier cycle, so a request arriving together with a strobe waits for the
  // next one. The copy takes the shadow value including a same-cycle write.
  // Products always use the bank that was active before this edge.
  always_comb begin
    applySwap     = iEnSample_300k & swapPending_q;
    swapPending_d = iCoeffSwap | (swapPending_q & ~iEnSample_300k);
    for (int k = 0; k < TAPS; k++) begin
      coefShadow_d[k] = coefShadow_q[k];
      if (iCoeffWe && (int'(iCoeffAddr) == k)) begin
        coefShadow_d[k] = iCoeffData;
      end
      coefActive_d[k] = applySwap ? coefShadow_d[k] : coefActive_q[k];
      tapProd[k]      = PROD_W'(iFirIn) * PROD_W'(coefActive_q[k]);
      rShift_d[k]     = rShift_q[k];
    end
    if (iEnSample_300k) begin
      rShift_d[0] = iCascadeIn + ACC_W'(tapProd[0]);
      for (int k = 1; k < TAPS; k++) begin
        rShift_d[k] = rShift_q[k-1] + ACC_W'(tapProd[k]);
      end
    end
  end

  // strobeDly_q marks the cycle in which the chain output holds a fresh sum,
  // which is what the output stage registers one edge later.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int k = 0; k < TAPS; k++) begin
        coefActive_q[k] <= '0;
        coefShadow_q[k] <= '0;
        rShift_q[k]     <= '0;
      end
      swapPending_q <= 1'b0;
      strobeDly_q   <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        coefActive_q[k] <= coefActive_d[k];
        coefShadow_q[k] <= coefShadow_d[k];
        rShift_q[k]     <= rShift_d[k];
      end
      swapPending_q <= swapPending_d;
      strobeDly_q   <= iEnSample_300k;
    end
  end

  fir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) uRoundSat (
    .clk_i    (iClk_12M),
    .rst_ni   (iRsn),
    .valid_i  (strobeDly_q),
    .acc_i    (rShift_q[TAPS-1]),
    .clrSat_i (iClrSat),
    .data_o   (oFirOut),
    .valid_o  (oValid),
    .sat_o    (oSat)
  );

  assign oCascadeOut  = rShift_q[TAPS-1];
  assign oSwapPending = swapPending_q;

endmodule
